// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports.
// Data wins arbitration unless fetch has lost STARVE_MAX times in a row.
module mem_arbiter #(
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_ren,
    input  logic          d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_ren,
    output logic          m_wen,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] LAT_C  = CW'(LATENCY);
    localparam logic [SW-1:0] SMAX_C = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_owner_d;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [DW-1:0]   r_wdata;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_starve;
    logic [DW-1:0]   r_i_rdata;
    logic [DW-1:0]   r_d_rdata;

    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_last;

    assign w_d_req   = d_ren | d_wen;
    assign w_grant_i = i_req && (!w_d_req || (r_starve == SMAX_C));
    assign w_grant_d = w_d_req && !w_grant_i;
    assign w_last    = (r_cnt == CW'(1));

    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Memory strobes and ready pulses are pure functions of state, so reset clears them at once.
    always_comb begin
        w_state_next = r_state;
        m_ren        = 1'b0;
        m_wen        = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_i || w_grant_d) begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy    = 1'b1;
                m_ren   = !r_we;
                m_wen   = r_we;
                m_addr  = r_addr;
                m_wdata = r_wdata;
                if (w_last) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                busy         = 1'b1;
                i_ready      = !r_owner_d;
                d_ready      = r_owner_d;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner_d <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_starve  <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (r_state == ST_IDLE && (w_grant_i || w_grant_d)) begin
                r_owner_d <= w_grant_d;
                r_addr    <= w_grant_d ? d_addr : i_addr;
                r_we      <= w_grant_d && d_wen;
                r_wdata   <= (w_grant_d && d_wen) ? d_wdata : '0;
                r_cnt     <= LAT_C;
                if (w_grant_i) begin
                    r_starve <= '0;
                end else if (i_req && (r_starve != SMAX_C)) begin
                    r_starve <= r_starve + 1'b1;
                end
            end
            if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt - CW'(1);
                // Read data is captured on the edge that closes the final access cycle.
                if (w_last && !r_we) begin
                    if (r_owner_d) begin
                        r_d_rdata <= m_rdata;
                    end else begin
                        r_i_rdata <= m_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences and
// a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int SM  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_ren = 1'b0;
    logic        d_wen = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_ren;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SM), .AW(32), .DW(32)) u_dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'h2002_0005 : (32'hA500_0000 | i);
    endfunction

    // Memory contents are reloaded whenever reset is held across an edge.
    assign m_rdata = mem[m_addr[7:0]];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (m_wen) begin
            mem[m_addr[7:0]] <= m_wdata;
        end
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (i_ready || d_ready) check("ready_exclusive", i_ready && d_ready, 0);
    end

    function automatic logic [159:0] all_outs();
        return {i_rdata, i_ready, d_rdata, d_ready, m_ren, m_wen, m_addr, m_wdata, busy};
    endfunction

    task automatic drop_all();
        i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    endtask

    typedef struct {
        bit          is_d;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [8];

    task automatic run_single(input vec_t v, input int idx);
        int  k;
        logic exp_w;
        exp_w = v.is_d && v.wen;
        @(posedge clock); #1;
        if (v.is_d) begin
            d_ren = v.ren; d_wen = v.wen; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        for (k = 0; k < 20; k++) begin
            @(negedge clock);
            if (k == 0) check($sformatf("v%0d_idle_busy", idx), busy, 0);
            if (k >= 1 && k <= LAT)
                check($sformatf("v%0d_access", idx),
                      {busy, m_ren, m_wen, m_addr, exp_w ? m_wdata : 32'h0},
                      {1'b1, !exp_w, exp_w, v.addr, exp_w ? v.wdata : 32'h0});
            if (i_ready || d_ready) break;
        end
        $display("vec %0d: d=%0b ren=%0b wen=%0b addr=%h ready_at=%0d i_rdata=%h d_rdata=%h",
                 idx, v.is_d, v.ren, v.wen, v.addr, k, i_rdata, d_rdata);
        check($sformatf("v%0d_latency", idx), k, LAT + 1);
        check($sformatf("v%0d_ready_owner", idx), {i_ready, d_ready}, {!v.is_d, v.is_d});
        check($sformatf("v%0d_rdata", idx), {i_rdata, d_rdata}, {v.exp_i, v.exp_d});
        check($sformatf("v%0d_resp_mem", idx), {m_ren, m_wen, m_addr, m_wdata, busy}, 67'h1);
        drop_all();
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (!(i_ready || d_ready) && cnt < 16);
    endtask

    // Random-phase model state
    bit          i_pend, d_pend, active, owner_d, cur_we;
    logic [31:0] cur_addr, cur_wdata, exp_i, exp_d;
    int          done_at, free_at, starve;

    initial begin
        int cnt;
        vec_t v;

        // Reset and idle
        repeat (3) @(posedge clock);
        #1 check("outs_in_reset", all_outs(), 0);
        @(negedge clock) reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle_outs_zero", all_outs(), 0);
        end
        $display("reset/idle: 10 cycles observed");

        // Directed table
        vecs[0] = '{0, 0, 0, 32'h10, 32'h0,         32'h2002_0005, 32'h0};
        vecs[1] = '{1, 0, 1, 32'h40, 32'hDEAD_BEEF, 32'h2002_0005, 32'h0};
        vecs[2] = '{1, 1, 0, 32'h40, 32'h0,         32'h2002_0005, 32'hDEAD_BEEF};
        vecs[3] = '{0, 0, 0, 32'h40, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[4] = '{1, 1, 1, 32'h41, 32'h0000_0022, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[5] = '{1, 1, 0, 32'h41, 32'h0,         32'hDEAD_BEEF, 32'h0000_0022};
        vecs[6] = '{0, 0, 0, 32'h03, 32'h0,         32'hA500_0003, 32'h0000_0022};
        vecs[7] = '{1, 1, 0, 32'h05, 32'h0,         32'hA500_0003, 32'hA500_0005};
        for (int i = 0; i < 8; i++) run_single(vecs[i], i);

        // Simultaneous fetch and data read: data first, fetch LAT+2 later
        @(posedge clock); #1;
        i_req = 1'b1; i_addr = 32'h10; d_ren = 1'b1; d_addr = 32'h07;
        wait_ready(cnt);
        $display("simul: first ready after %0d cycles i=%0b d=%0b", cnt, i_ready, d_ready);
        check("simul_first_lat", cnt, LAT + 2);
        check("simul_first_owner", {i_ready, d_ready}, 2'b01);
        check("simul_d_rdata", d_rdata, 32'hA500_0007);
        d_ren = 1'b0;
        wait_ready(cnt);
        $display("simul: second ready after %0d cycles i=%0b d=%0b", cnt, i_ready, d_ready);
        check("simul_second_gap", cnt, LAT + 2);
        check("simul_second_owner", {i_ready, d_ready}, 2'b10);
        check("simul_i_rdata", i_rdata, 32'h2002_0005);
        drop_all();

        // Starvation: grant order D,D,D,D,I repeating
        @(posedge clock); #1;
        i_req = 1'b1; i_addr = 32'h03; d_ren = 1'b1; d_addr = 32'h05;
        for (int g = 0; g < 10; g++) begin
            wait_ready(cnt);
            $display("starve grant %0d: %s after %0d cycles", g, i_ready ? "I" : "D", cnt);
            check($sformatf("starve_g%0d_owner", g), {i_ready, d_ready},
                  (g % 5 == 4) ? 2'b10 : 2'b01);
            check($sformatf("starve_g%0d_gap", g), cnt, LAT + 2);
        end
        drop_all();

        // Reset asserted in the middle of an access
        @(posedge clock); #1;
        d_ren = 1'b1; d_addr = 32'h09;
        @(negedge clock);
        @(negedge clock);
        check("midreset_busy_before", {busy, m_ren}, 2'b11);
        reset = 1'b0;
        #1 check("midreset_outs_zero", all_outs(), 0);
        drop_all();
        @(posedge clock); #1;
        check("midreset_outs_held", all_outs(), 0);
        @(negedge clock) reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("midreset_no_ready", {i_ready, d_ready, busy}, 0);
        end
        $display("mid-access reset: recovered");
        v = '{1, 1, 0, 32'h05, 32'h0, 32'h0, 32'hA500_0005};
        run_single(v, 8);

        // Randomized traffic against the reference model
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        i_pend = 0; d_pend = 0; active = 0; free_at = 0; starve = 0;
        exp_i = 32'h0; exp_d = 32'hA500_0005;
        for (int c = 0; c < 700; c++) begin
            @(posedge clock); #1;
            if (c < 500) begin
                if (!i_pend && $urandom_range(0, 2) == 0) begin
                    i_pend = 1; i_req = 1'b1; i_addr = $urandom_range(0, 31);
                end
                if (!d_pend && $urandom_range(0, 1) == 0) begin
                    int t;
                    t = $urandom_range(0, 3);
                    d_pend = 1; d_addr = $urandom_range(0, 31); d_wdata = $urandom;
                    d_ren = (t != 1); d_wen = (t == 1 || t == 2);
                end
            end
            if (!active && c >= free_at && (i_pend || d_pend)) begin
                if (i_pend && (!d_pend || starve == SM)) begin
                    owner_d = 0; starve = 0;
                    cur_addr = i_addr; cur_we = 0;
                end else begin
                    owner_d = 1;
                    if (i_pend && starve < SM) starve++;
                    cur_addr = d_addr; cur_we = d_wen; cur_wdata = d_wdata;
                end
                active = 1; done_at = c + LAT + 1; free_at = c + LAT + 2;
            end
            @(negedge clock);
            check("rand_ready", {i_ready, d_ready},
                  {active && c == done_at && !owner_d, active && c == done_at && owner_d});
            if (active && c == done_at) begin
                if (owner_d) begin
                    if (cur_we) ref_mem[cur_addr[7:0]] = cur_wdata;
                    else exp_d = ref_mem[cur_addr[7:0]];
                    d_pend = 0; d_ren = 1'b0; d_wen = 1'b0;
                end else begin
                    exp_i = ref_mem[cur_addr[7:0]];
                    i_pend = 0; i_req = 1'b0;
                end
                $display("rand c=%0d: %s we=%0b addr=%h i_rdata=%h d_rdata=%h",
                         c, owner_d ? "D" : "I", cur_we, cur_addr, i_rdata, d_rdata);
                check("rand_rdata", {i_rdata, d_rdata}, {exp_i, exp_d});
                active = 0;
            end
        end
        check("rand_drained", {i_pend, d_pend, active}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one single-port `Memory` instance between the pipeline's instruction-fetch port and its data (MEM-stage) port, for a unified instruction/data memory build of the 5-stage MIPS core. It accepts held requests from both ports and grants one at a time. It drives the memory for a fixed number of access cycles and returns read data with a one-cycle `ready` pulse, which the pipeline uses as its stall-release condition. Data accesses have priority; a starvation counter guarantees instruction fetch progress.

## Interface
- `LATENCY`, default 1: memory access cycles per transaction (≥1); `m_*` driven for exactly this many cycles.
- `STARVE_MAX`, default 4: consecutive lost arbitrations after which a pending fetch wins (≥1).
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `i_req`  in  1  fetch request; held high until `i_ready`.
- `i_addr`  in  AW  fetch word address; stable while `i_req`.
- `i_rdata`  out  DW  fetched instruction; valid when `i_ready`, held until the next fetch completes.
- `i_ready`  out  1  one-cycle completion pulse for fetch.
- `d_ren`  in  1  data read request; held until `d_ready`.
- `d_wen`  in  1  data write request; held until `d_ready`; overrides `d_ren` if both high.
- `d_addr`  in  AW  data address; stable while requesting.
- `d_wdata`  in  DW  write data; stable while `d_wen`.
- `d_rdata`  out  DW  load data; valid when `d_ready` after a read, held until the next data read completes.
- `d_ready`  out  1  one-cycle completion pulse for data (read or write).
- `m_ren`, `m_wen`  out  1 each  memory read/write enables.
- `m_addr`  out  AW  memory address.
- `m_wdata`  out  DW  memory write data.
- `m_rdata`  in  DW  memory read data.
- `busy`  out  1  high in ACCESS and RESP states.

## Operation
- States:
  - IDLE: arbitration happens here only.
  - ACCESS: memory is driven for the granted owner.
  - RESP: one-cycle `ready` pulse to the owner.
- IDLE behaviour:
  - No request: stay in IDLE.
  - Otherwise: latch owner, address, write flag and write data; load the cycle counter with `LATENCY`; go to ACCESS.
- Grant rule in IDLE:
  - Fetch wins if `i_req` and (no data request, or `starve_cnt == STARVE_MAX`).
  - Otherwise data wins.
- Starvation counter (`starve_cnt`):
  - Increments (saturating at `STARVE_MAX`) when data wins while `i_req` is high.
  - Clears to 0 when fetch wins.
  - Unchanged otherwise.
- ACCESS behaviour:
  - `m_addr`/`m_wdata` come from the latched values.
  - `m_wen` is high for data writes only; `m_ren` is high otherwise. They are never both high.
  - Counter decrements each cycle.
  - On the last cycle (counter==1), register `m_rdata` into the owner's rdata (reads only), then go to RESP.
- RESP behaviour:
  - Owner's `ready` is high for this cycle only; all `m_*` are 0.
  - Always return to IDLE. The requester drops or changes its request on the edge ending RESP, so a held request is never re-granted twice.
- Write transactions leave `d_rdata` unchanged. Fetches never touch `d_rdata`, and data accesses never touch `i_rdata`.
- Requests that change or drop mid-transaction are ignored: latched values are used to completion.

## Timing
- Reset (async, any state, including mid-ACCESS):
  - State goes to IDLE, `starve_cnt`=0, counter=0.
  - All outputs 0: `m_*`, `i_ready`, `d_ready`, `i_rdata`, `d_rdata`, `busy`.
  - The in-flight access is abandoned and no `ready` is issued for it.
- Request visible in IDLE in cycle t: ACCESS spans cycles t+1..t+LATENCY; `ready` pulses in cycle t+LATENCY+1; IDLE returns at t+LATENCY+2.
- Per-transaction occupancy is LATENCY+2 cycles. Back-to-back throughput is one transaction per LATENCY+2 cycles.
- `m_rdata` is sampled at the posedge ending the last ACCESS cycle. `rdata` is valid from the start of RESP.
- Simultaneous `i_req` and data request in IDLE: data is granted unless `starve_cnt == STARVE_MAX`.
- With both ports continuously requesting: fetch is granted at least once every STARVE_MAX+1 grants.
- `ready` is never high for both ports in the same cycle. `ready` is never high outside RESP.

## Test plan
- Reset, then idle: all outputs 0 and `busy`=0 for 10 cycles. Assert reset mid-ACCESS (LATENCY=3): outputs 0 immediately, no `ready`, and the next request is served normally.
- Single fetch, LATENCY=1, `i_addr`=0x10, memory word 0x2002_0005: `m_ren`=1 with `m_addr`=0x10 in cycle t+1; `i_ready`=1 and `i_rdata`=0x2002_0005 in cycle t+2; IDLE at t+3.
- Data write then read, LATENCY=2: write 0xDEAD_BEEF to 0x40 gives `m_wen`=1 for 2 cycles and `d_ready`; `d_rdata` stays 0. Reading 0x40 then returns 0xDEAD_BEEF on `d_ready`.
- Simultaneous `i_req` and `d_ren` in IDLE with `starve_cnt`=0: data is granted first; fetch `i_ready` follows exactly LATENCY+2 cycles after `d_ready`.
- Starvation, STARVE_MAX=4: `i_req` held and data requests continuous. Grant order is D,D,D,D,I,D,… and `starve_cnt` sequence is 1,2,3,4,0.
- `d_ren` and `d_wen` both high: write only (`m_wen`=1, `m_ren`=0), and `d_rdata` is unchanged.
